// File: rtl/sseg_scan_ctrl.sv
// Four-digit seven-segment scanner showing R/N/D steering glyphs, plus a
// backtrack indicator held for a programmable number of full scan frames.
module sseg_scan_ctrl #(
    parameter int CLK_DIV   = 100000,
    parameter int BT_FRAMES = 250
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] dir,
    input  logic       backtrack_req,
    output logic       ce,
    output logic [3:0] an_sel,
    output logic [6:0] char_sel,
    output logic       backtrack_active
);
    localparam int PW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int FW = (BT_FRAMES > 1) ? $clog2(BT_FRAMES + 1) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);
    localparam logic [FW-1:0] FRAMES_LD = FW'(BT_FRAMES);

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_R     = 7'b0101111;
    localparam logic [6:0] SEG_N     = 7'b0101011;
    localparam logic [6:0] SEG_D     = 7'b0100001;

    typedef enum logic {
        BT_IDLE,
        BT_ACTIVE
    } bt_state_e;

    logic [PW-1:0] presc_q, presc_d;
    logic [1:0]    idx_q, idx_d;
    logic [1:0]    dir_q, dir_d;
    logic [3:0]    an_sel_q, an_sel_d;
    logic [6:0]    char_sel_q, char_sel_d;
    logic [FW-1:0] frames_q, frames_d;
    bt_state_e     state_q, state_d;

    function automatic logic [3:0] anode_of(input logic [1:0] idx);
        logic [3:0] an;
        case (idx)
            2'd0:    an = 4'b1110;
            2'd1:    an = 4'b1101;
            2'd2:    an = 4'b1011;
            default: an = 4'b0111;
        endcase
        return an;
    endfunction

    // Each digit lights only for its own direction; dir 11 matches none and blanks all.
    function automatic logic [6:0] glyph_of(input logic [1:0] idx, input logic [1:0] d);
        logic [6:0] seg;
        seg = SEG_BLANK;
        case (idx)
            2'd0:    if (d == 2'b10) seg = SEG_R;
            2'd1:    if (d == 2'b00) seg = SEG_N;
            2'd2:    if (d == 2'b01) seg = SEG_D;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

    always_comb begin
        ce         = en && (presc_q == PRESC_MAX);
        presc_d    = presc_q;
        idx_d      = idx_q;
        dir_d      = dir_q;
        an_sel_d   = 4'b1111;
        char_sel_d = char_sel_q;
        if (en) begin
            if (ce) begin
                presc_d = '0;
                idx_d   = idx_q + 2'd1;
                // Direction is only sampled at the frame boundary so a frame never mixes glyphs.
                if (idx_q == 2'd3) begin
                    dir_d = dir;
                end
            end else begin
                presc_d = presc_q + PW'(1);
            end
            an_sel_d   = anode_of(idx_d);
            char_sel_d = glyph_of(idx_d, dir_d);
        end
    end

    always_comb begin
        state_d  = state_q;
        frames_d = frames_q;
        if (state_q == BT_IDLE) begin
            if (backtrack_req) begin
                state_d  = BT_ACTIVE;
                frames_d = FRAMES_LD;
            end
        end else begin
            // A retrigger outranks the final decrement, keeping the indication alive.
            if (backtrack_req) begin
                frames_d = FRAMES_LD;
            end else if (ce && (idx_q == 2'd3) && (frames_q != '0)) begin
                frames_d = frames_q - FW'(1);
                if (frames_q == FW'(1)) begin
                    state_d = BT_IDLE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q    <= '0;
            idx_q      <= 2'd0;
            dir_q      <= 2'b00;
            an_sel_q   <= 4'b1111;
            char_sel_q <= SEG_BLANK;
            frames_q   <= '0;
            state_q    <= BT_IDLE;
        end else begin
            presc_q    <= presc_d;
            idx_q      <= idx_d;
            dir_q      <= dir_d;
            an_sel_q   <= an_sel_d;
            char_sel_q <= char_sel_d;
            frames_q   <= frames_d;
            state_q    <= state_d;
        end
    end

    assign an_sel           = an_sel_q;
    assign char_sel         = char_sel_q;
    assign backtrack_active = (state_q == BT_ACTIVE);

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Bench for sseg_scan_ctrl: fixed start-up vector table, directed corner sequences,
// then random traffic against a cycle-level reference model.
module tb_sseg_scan_ctrl;
    localparam int CLK_DIV   = 4;
    localparam int BT_FRAMES = 2;

    localparam logic [6:0] G_BLANK = 7'b1111111;
    localparam logic [6:0] G_R     = 7'b0101111;
    localparam logic [6:0] G_N     = 7'b0101011;
    localparam logic [6:0] G_D     = 7'b0100001;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [1:0] dir;
    logic       backtrack_req;
    logic       ce;
    logic [3:0] an_sel;
    logic [6:0] char_sel;
    logic       backtrack_active;

    always #5 clk = ~clk;

    sseg_scan_ctrl #(.CLK_DIV(CLK_DIV), .BT_FRAMES(BT_FRAMES)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .en               (en),
        .dir              (dir),
        .backtrack_req    (backtrack_req),
        .ce               (ce),
        .an_sel           (an_sel),
        .char_sel         (char_sel),
        .backtrack_active (backtrack_active)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: slot position, digit, frame direction, frames remaining.
    int         m_presc, m_idx, m_dir, m_left;
    bit         m_act;
    logic [3:0] m_an;
    logic [6:0] m_char;
    logic [3:0] AN_CODE [4] = '{4'hE, 4'hD, 4'hB, 4'h7};

    typedef struct {
        logic       en;
        logic [1:0] dir;
        logic       req;
        logic       ce;
        logic [3:0] an;
        logic [6:0] chr;
        logic       bt;
    } vec_t;
    vec_t vt [24];

    function automatic logic [6:0] glyph(input int i, input int d);
        if (i == 0 && d == 2) return G_R;
        if (i == 1 && d == 0) return G_N;
        if (i == 2 && d == 1) return G_D;
        return G_BLANK;
    endfunction

    function automatic bit m_ce();
        return en && (m_presc == CLK_DIV - 1);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: wait budget expired at %0t", name, $time);
    endtask

    task automatic model_reset();
        m_presc = 0; m_idx = 0; m_dir = 0; m_left = 0; m_act = 0;
        m_an = 4'hF; m_char = G_BLANK;
    endtask

    task automatic model_edge();
        bit fire;
        fire = m_ce();
        if (backtrack_req) begin
            m_act = 1; m_left = BT_FRAMES;
        end else if (m_act && fire && m_idx == 3) begin
            m_left--;
            if (m_left == 0) m_act = 0;
        end
        if (en) begin
            if (fire) begin
                m_presc = 0;
                if (m_idx == 3) m_dir = int'(dir);
                m_idx = (m_idx + 1) % 4;
            end else begin
                m_presc++;
            end
            m_an   = AN_CODE[m_idx];
            m_char = glyph(m_idx, m_dir);
        end else begin
            m_an = 4'hF;
        end
    endtask

    task automatic cmp_model();
        check("ce", 32'(ce), 32'(m_ce()));
        check("an_sel", 32'(an_sel), 32'(m_an));
        check("char_sel", 32'(char_sel), 32'(m_char));
        check("backtrack_active", 32'(backtrack_active), 32'(m_act));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        cmp_model();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ce"}, 32'(ce), 32'(1'b0));
        check({tag, "_an"}, 32'(an_sel), 32'(4'hF));
        check({tag, "_char"}, 32'(char_sel), 32'(G_BLANK));
        check({tag, "_bt"}, 32'(backtrack_active), 32'(1'b0));
    endtask

    // Negative arguments are wildcards.
    task automatic wait_state(input string name, input int idx, input int presc, input int dq, input int budget);
        int n;
        n = 0;
        while (!((idx < 0 || m_idx == idx) && (presc < 0 || m_presc == presc) && (dq < 0 || m_dir == dq))
               && n < budget) begin
            tick();
            n++;
        end
        if (n >= budget) timeout(name);
    endtask

    task automatic count_until_fall(input string name);
        int  n3;
        bit  fell;
        n3   = 0;
        fell = 0;
        for (int i = 0; i < CLK_DIV * 4 * 5 && !fell; i++) begin
            if (m_ce() && m_idx == 3) n3++;
            tick();
            if (backtrack_active == 1'b0) fell = 1;
        end
        check({name, "_fell"}, 32'(fell), 32'(1));
        check({name, "_idx3_ce_count"}, 32'(n3), 32'(BT_FRAMES));
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; dir = 2'b00; backtrack_req = 1'b0;
        model_reset();

        // Start-up with dir=01 held: N shows in frame 1 (dir_q still 00), D from frame 2.
        vt[0]  = '{1'b1, 2'b01, 1'b0, 1'b0, 4'hE, G_BLANK, 1'b0};
        vt[1]  = '{1'b1, 2'b01, 1'b0, 1'b0, 4'hE, G_BLANK, 1'b0};
        vt[2]  = '{1'b1, 2'b01, 1'b0, 1'b1, 4'hE, G_BLANK, 1'b0};
        vt[3]  = '{1'b1, 2'b01, 1'b0, 1'b0, 4'hD, G_N,     1'b0};
        vt[4]  = '{1'b1, 2'b01, 1'b0, 1'b0, 4'hD, G_N,     1'b0};
        vt[5]  = '{1'b1, 2'b01, 1'b0, 1'b0, 4'hD, G_N,     1'b0};
        vt[6]  = '{1'b1, 2'b01, 1'b0, 1'b1, 4'hD, G_N,     1'b0};
        vt[7]  = '{1'b1, 2'b01, 1'b0, 1'b0, 4'hB, G_BLANK, 1'b0};
        vt[8]  = '{1'b1, 2'b01, 1'b0, 1'b0, 4'hB, G_BLANK, 1'b0};
        vt[9]  = '{1'b1, 2'b01, 1'b0, 1'b0, 4'hB, G_BLANK, 1'b0};
        vt[10] = '{1'b1, 2'b01, 1'b0, 1'b1, 4'hB, G_BLANK, 1'b0};
        vt[11] = '{1'b1, 2'b01, 1'b0, 1'b0, 4'h7, G_BLANK, 1'b0};
        vt[12] = '{1'b1, 2'b01, 1'b0, 1'b0, 4'h7, G_BLANK, 1'b0};
        vt[13] = '{1'b1, 2'b01, 1'b0, 1'b0, 4'h7, G_BLANK, 1'b0};
        vt[14] = '{1'b1, 2'b01, 1'b0, 1'b1, 4'h7, G_BLANK, 1'b0};
        vt[15] = '{1'b1, 2'b01, 1'b0, 1'b0, 4'hE, G_BLANK, 1'b0};
        vt[16] = '{1'b1, 2'b01, 1'b0, 1'b0, 4'hE, G_BLANK, 1'b0};
        vt[17] = '{1'b1, 2'b01, 1'b0, 1'b0, 4'hE, G_BLANK, 1'b0};
        vt[18] = '{1'b1, 2'b01, 1'b0, 1'b1, 4'hE, G_BLANK, 1'b0};
        vt[19] = '{1'b1, 2'b01, 1'b0, 1'b0, 4'hD, G_BLANK, 1'b0};
        vt[20] = '{1'b1, 2'b01, 1'b0, 1'b0, 4'hD, G_BLANK, 1'b0};
        vt[21] = '{1'b1, 2'b01, 1'b0, 1'b0, 4'hD, G_BLANK, 1'b0};
        vt[22] = '{1'b1, 2'b01, 1'b0, 1'b1, 4'hD, G_BLANK, 1'b0};
        vt[23] = '{1'b1, 2'b01, 1'b0, 1'b0, 4'hB, G_D,     1'b0};

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        for (int k = 0; k < 24; k++) begin
            en = vt[k].en; dir = vt[k].dir; backtrack_req = vt[k].req;
            @(posedge clk);
            model_edge();
            @(negedge clk);
            check($sformatf("vec%0d_ce", k), 32'(ce), 32'(vt[k].ce));
            check($sformatf("vec%0d_an", k), 32'(an_sel), 32'(vt[k].an));
            check($sformatf("vec%0d_char", k), 32'(char_sel), 32'(vt[k].chr));
            check($sformatf("vec%0d_bt", k), 32'(backtrack_active), 32'(vt[k].bt));
        end

        // Direction change mid-frame only takes effect from the next frame.
        dir = 2'b00;
        wait_state("wait_n_frame", 1, -1, 0, 64);
        dir = 2'b10;
        for (int n = 0; n < 32 && m_idx != 0; n++) begin
            tick();
            if (m_idx == 1) check("n_held_mid_frame", 32'(char_sel), 32'(G_N));
        end
        for (int n = 0; n < CLK_DIV * 4; n++) begin
            tick();
            if (m_idx == 0) check("r_at_idx0", 32'(char_sel), 32'(G_R));
            if (m_idx == 1) check("idx1_blank", 32'(char_sel), 32'(G_BLANK));
        end

        // Single request: held until the BT_FRAMES-th index-3 ce.
        backtrack_req = 1'b1;
        tick();
        backtrack_req = 1'b0;
        check("bt_rise", 32'(backtrack_active), 32'(1));
        count_until_fall("bt_single");

        // Retrigger coinciding with the final decrement.
        backtrack_req = 1'b1;
        tick();
        backtrack_req = 1'b0;
        for (int n = 0; n < 64 && !(m_left == 1 && m_ce() && m_idx == 3); n++) tick();
        if (!(m_left == 1 && m_ce() && m_idx == 3)) timeout("wait_final_dec");
        backtrack_req = 1'b1;
        tick();
        backtrack_req = 1'b0;
        check("bt_retrigger_held", 32'(backtrack_active), 32'(1));
        count_until_fall("bt_retrigger");

        // Scan freeze for 10 cycles mid-slot, request still accepted meanwhile.
        wait_state("wait_freeze_point", 1, 2, -1, 64);
        en = 1'b0;
        for (int n = 0; n < 10; n++) begin
            backtrack_req = (n == 4);
            tick();
            check("frozen_ce", 32'(ce), 32'(1'b0));
            check("frozen_an", 32'(an_sel), 32'(4'hF));
        end
        backtrack_req = 1'b0;
        check("req_while_frozen", 32'(backtrack_active), 32'(1));
        en = 1'b1;
        tick();
        check("resume_an", 32'(an_sel), 32'(4'hD));
        check("resume_ce", 32'(ce), 32'(1'b1));
        tick();
        check("resume_next_digit", 32'(an_sel), 32'(4'hB));

        // Asynchronous reset while ACTIVE at index 2, then invalid direction.
        backtrack_req = 1'b1;
        tick();
        backtrack_req = 1'b0;
        wait_state("wait_idx2", 2, 1, -1, 64);
        check("active_before_reset", 32'(backtrack_active), 32'(1));
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("async_reset");
        model_reset();
        @(negedge clk);
        check_reset_outputs("held_reset");
        rst_n = 1'b1; dir = 2'b11;
        wait_state("wait_dir11", 0, -1, 3, 64);
        for (int n = 0; n < CLK_DIV * 8; n++) begin
            tick();
            check("dir11_blank", 32'(char_sel), 32'(G_BLANK));
        end

        // Random traffic with occasional asynchronous resets.
        for (int n = 0; n < 2000; n++) begin
            en            = ($urandom_range(0, 7) != 0);
            dir           = 2'($urandom_range(0, 3));
            backtrack_req = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 300) == 0) begin
                #2 rst_n = 1'b0;
                #1 model_reset();
                cmp_model();
                @(negedge clk);
                rst_n = 1'b1;
            end else begin
                tick();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sseg_scan_ctrl.md
SSEG_SCAN_CTRL -- requirements
Module: sseg_scan_ctrl

Interface
REQ-001 Parameter CLK_DIV, default 100000, clk cycles per digit slot (1 kHz digit rate at 100 MHz); legal range >= 2.
REQ-002 Parameter BT_FRAMES, default 250, number of full 4-digit scan frames for which backtrack_active is held after a request; legal range >= 1.
REQ-003 clk  input  1  system clock; the single clock domain.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 en  input  1  scan enable; low freezes scanning.
REQ-006 dir  input  2  steering direction: 00 neutral, 01 drive, 10 reverse, 11 invalid.
REQ-007 backtrack_req  input  1  single-cycle request to start or retrigger the backtrack indication.
REQ-008 ce  output  1  one-cycle strobe marking the sample point of an_sel/char_sel for the display output stage.
REQ-009 an_sel  output  4  active-low anode select, one-hot-low.
REQ-010 char_sel  output  7  active-low segment pattern, gfedcba order.
REQ-011 backtrack_active  output  1  high while the backtrack indication is in force.

Function
REQ-012 Prescaler counts 0..CLK_DIV-1 while en=1 and wraps to 0; ce SHALL be 1 for exactly the cycle in which the count equals CLK_DIV-1, else 0.
REQ-013 A 2-bit digit index SHALL advance on each ce cycle, 0->1->2->3->0.
REQ-014 an_sel SHALL be registered from the index: 0->1110, 1->1101, 2->1011, 3->0111; it changes in the cycle after ce and is stable for the following CLK_DIV-1 cycles.
REQ-015 dir SHALL be captured into dir_q only on the ce that wraps the index 3->0; no digit pattern changes direction mid-frame.
REQ-016 char_sel per index, from dir_q: index0 = 0101111 (R) if dir_q=10, else 1111111; index1 = 0101011 (N) if dir_q=00, else 1111111; index2 = 0100001 (D) if dir_q=01, else 1111111; index3 = 1111111.
REQ-017 dir_q=11 SHALL blank all digits (char_sel 1111111 at every index).
REQ-018 char_sel SHALL update in the same cycle as an_sel.
REQ-019 Backtrack FSM states: IDLE and ACTIVE; backtrack_active = 1 exactly in ACTIVE, registered.
REQ-020 IDLE -> ACTIVE on backtrack_req=1; the frame counter loads BT_FRAMES.
REQ-021 In ACTIVE, the frame counter decrements on each ce with index=3; a decrement reaching 0 returns the FSM to IDLE in that same edge.
REQ-022 backtrack_req in ACTIVE SHALL reload BT_FRAMES (retrigger); if it coincides with the final decrement, reload wins and the FSM stays ACTIVE.
REQ-023 With en=0: prescaler, index, dir_q and frame counter hold; ce=0; an_sel is driven to 1111; char_sel holds its value; backtrack_req is still accepted.
REQ-024 When en returns to 1, scanning resumes from the held prescaler and index values; an_sel is restored from the index on the first en=1 edge.
REQ-025 The frame counter width is clog2(BT_FRAMES+1); it does not wrap below 0.

Reset
REQ-026 With rst_n=0 asynchronously: prescaler=0, index=0, dir_q=00, frame counter=0, FSM=IDLE, ce=0, an_sel=1111, char_sel=1111111, backtrack_active=0.
REQ-027 Reset may be asserted at any time, including mid-frame or in ACTIVE; all state returns to the REQ-026 values.
REQ-028 Release of reset is synchronous to clk; the first ce occurs CLK_DIV cycles after the first edge with rst_n=1 and en=1.

Verification (bench uses CLK_DIV=4, BT_FRAMES=2)
REQ-029 Reset, then en=1, dir=01 held -> ce on cycles 4, 8, 12, 16; an_sel sequence 1101, 1011, 0111, 1110; from the second frame onward char_sel=0100001 only when an_sel=1011.
REQ-030 dir changes 00->10 while index=1 -> the remainder of the frame still shows N at index1; from the next frame, R appears at index0 and index1 is blank.
REQ-031 backtrack_req pulse -> backtrack_active rises on the next edge and falls on the edge of the second ce with index=3.
REQ-032 Retrigger: req on the cycle of the final index=3 ce -> backtrack_active stays 1 for two further frames.
REQ-033 en=0 for 10 cycles mid-frame -> no ce, an_sel=1111; after en=1, scanning resumes at the same index and prescaler value with no skipped digit.
REQ-034 rst_n low for 1 cycle while ACTIVE at index 2 -> outputs immediately take the REQ-026 values; dir=11 thereafter -> char_sel=1111111 on all digits.
